// File: rtl/id_stage_pipe.sv
// id_stage_pipe: instruction decode stage with register file, hazard
// detection and the ID/EX pipeline register.
//
// Ports
//   clock, reset        single clock; reset is asynchronous, active low
//   instruction, pc_in  IF/ID instruction word and PC
//   wb_en/dest/data     register-file writeback port (write-through on read)
//   mem_wb_en/mem_dest  destination of the instruction currently in MEM
//   flush               branch taken in EX; squashes the instruction in ID
//   stall_out           combinational hazard; IF and IF/ID hold
//   ex_*                registered ID/EX control and data
module id_stage_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter bit FORWARD_EN = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mem_wb_en,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              flush,
  output logic              stall_out,
  output logic              ex_valid,
  output logic [3:0]        ex_cmd,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_wb_en,
  output logic [1:0]        ex_br_type,
  output logic [DATA_W-1:0] ex_val1,
  output logic [DATA_W-1:0] ex_val2,
  output logic [DATA_W-1:0] ex_reg2,
  output logic [REG_AW-1:0] ex_dest,
  output logic [REG_AW-1:0] ex_src1,
  output logic [REG_AW-1:0] ex_src2,
  output logic [DATA_W-1:0] ex_pc
);

  localparam int NREG = 1 << REG_AW;

  typedef struct packed {
    logic [3:0]        cmd;
    logic              mem_read;
    logic              mem_write;
    logic              wb;
    logic [1:0]        br;
    logic              use1;     // rs is read
    logic              use2;     // rt is read
    logic              use_imm;  // val2 takes the immediate
    logic [REG_AW-1:0] dest;
  } dec_t;

  logic [5:0]        op;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [DATA_W-1:0] imm;
  dec_t              dec;

  assign op  = instruction[31:26];
  assign rs  = instruction[21 +: REG_AW];
  assign rt  = instruction[16 +: REG_AW];
  assign rd  = instruction[11 +: REG_AW];
  assign imm = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};

  // Decode. LD/ST/I-type use rs as the base/first operand.
  always_comb begin
    dec = '0;
    if (op >= 6'd1 && op <= 6'd31) begin
      dec.cmd  = op[3:0];
      dec.wb   = 1'b1;
      dec.dest = rd;
      dec.use1 = 1'b1;
      dec.use2 = 1'b1;
    end else if (op >= 6'd32 && op <= 6'd39) begin
      dec.cmd     = op[3:0];
      dec.wb      = 1'b1;
      dec.dest    = rt;
      dec.use1    = 1'b1;
      dec.use_imm = 1'b1;
    end else begin
      case (op)
        6'd40: begin
          dec.mem_read = 1'b1;
          dec.wb       = 1'b1;
          dec.dest     = rt;
          dec.use1     = 1'b1;
          dec.use_imm  = 1'b1;
        end
        6'd41: begin
          dec.mem_write = 1'b1;
          dec.use1      = 1'b1;
          dec.use2      = 1'b1;
          dec.use_imm   = 1'b1;
        end
        6'd42: begin
          dec.br   = 2'd1;
          dec.use1 = 1'b1;
        end
        6'd43: begin
          dec.br   = 2'd2;
          dec.use1 = 1'b1;
          dec.use2 = 1'b1;
        end
        6'd44: dec.br = 2'd3;
        default: dec = '0;
      endcase
    end
  end

  // Register file: r0 hard-wired to zero, reads bypass a same-cycle write.
  logic [DATA_W-1:0] rf [NREG];
  logic [DATA_W-1:0] rs_val, rt_val;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_en && wb_dest != '0) begin
      rf[wb_dest] <= wb_data;
    end
  end

  always_comb begin
    rs_val = rf[rs];
    if (rs == '0)                      rs_val = '0;
    else if (wb_en && wb_dest == rs)   rs_val = wb_data;
    rt_val = rf[rt];
    if (rt == '0)                      rt_val = '0;
    else if (wb_en && wb_dest == rt)   rt_val = wb_data;
  end

  // Hazard detection.
  function automatic logic hit(input logic used, input logic [REG_AW-1:0] src,
                               input logic en, input logic [REG_AW-1:0] dst);
    return used && (src != '0) && en && (src == dst);
  endfunction

  logic ex_hit, mem_hit, raw_stall, bubble;

  always_comb begin
    ex_hit  = hit(dec.use1, rs, ex_valid & ex_wb_en, ex_dest) |
              hit(dec.use2, rt, ex_valid & ex_wb_en, ex_dest);
    mem_hit = hit(dec.use1, rs, mem_wb_en, mem_dest) |
              hit(dec.use2, rt, mem_wb_en, mem_dest);
    // With forwarding only a load in EX cannot supply its result in time.
    raw_stall = FORWARD_EN ? (ex_hit & ex_mem_read) : (ex_hit | mem_hit);
  end

  assign stall_out = raw_stall & ~flush;
  assign bubble    = stall_out | flush;

  // ID/EX register. Data fields load every cycle; a bubble only zeroes control.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_valid     <= 1'b0;
      ex_cmd       <= '0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_wb_en     <= 1'b0;
      ex_br_type   <= '0;
      ex_val1      <= '0;
      ex_val2      <= '0;
      ex_reg2      <= '0;
      ex_dest      <= '0;
      ex_src1      <= '0;
      ex_src2      <= '0;
      ex_pc        <= '0;
    end else begin
      ex_val1 <= rs_val;
      ex_val2 <= dec.use_imm ? imm : rt_val;
      ex_reg2 <= rt_val;
      ex_dest <= dec.dest;
      ex_src1 <= rs;
      ex_src2 <= rt;
      ex_pc   <= pc_in;
      if (bubble) begin
        ex_valid     <= 1'b0;
        ex_cmd       <= '0;
        ex_mem_read  <= 1'b0;
        ex_mem_write <= 1'b0;
        ex_wb_en     <= 1'b0;
        ex_br_type   <= '0;
      end else begin
        ex_valid     <= 1'b1;
        ex_cmd       <= dec.cmd;
        ex_mem_read  <= dec.mem_read;
        ex_mem_write <= dec.mem_write;
        ex_wb_en     <= dec.wb;
        ex_br_type   <= dec.br;
      end
    end
  end

endmodule
